// File: rtl/dwc_sched.sv
`default_nettype none
//------------------------------------------------------------------------------
// dwc_sched : depthwise-conv PU array sequencer (weights, column stream, drain)
// Optional: DWC_SCHED_WATCHDOG_EN adds a DRAIN idle watchdog and err_timeout.
// Rev 1.0
//------------------------------------------------------------------------------
module dwc_sched #(
  parameter int UNIT_NUM = 16,
  parameter int K        = 3,
  parameter int COL_AW   = 10,
  parameter int TILE_W   = 8,
  parameter int GRP_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [COL_AW-1:0]     cfg_width,
  input  logic [TILE_W-1:0]     cfg_row_tiles,
  input  logic [GRP_W-1:0]      cfg_ch_groups,
  output logic                  w_rd_en,
  output logic [GRP_W-1:0]      w_rd_grp,
  output logic                  w_load,
  input  logic                  col_rdy,
  output logic                  col_rd_en,
  output logic [COL_AW-1:0]     col_rd_addr,
  output logic [TILE_W-1:0]     col_rd_tile,
  output logic [GRP_W-1:0]      col_rd_grp,
  output logic                  pu_in_valid,
  input  logic [UNIT_NUM*4-1:0] pu_out_valids,
  output logic                  busy,
  output logic                  tile_done,
  output logic                  done,
`ifdef DWC_SCHED_WATCHDOG_EN
  output logic                  err_timeout,
`endif
  output logic                  cfg_err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_W = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [COL_AW-1:0] c_K = COL_AW'(K);

  state_t              r_state;
  state_t              w_next;
  logic                r_lw_phase;
  logic [COL_AW-1:0]   r_width;
  logic [TILE_W-1:0]   r_rows;
  logic [GRP_W-1:0]    r_grps;
  logic [COL_AW-1:0]   r_col;
  logic [TILE_W-1:0]   r_tile;
  logic [GRP_W-1:0]    r_grp;
  logic [COL_AW-1:0]   r_out_cnt;
  logic                r_cfg_err;
  logic                r_pu_in_valid;

  logic                w_cfg_ok;
  logic                w_accept;
  logic                w_out_v;
  logic                w_hit;
  logic                w_last_col;
  logic                w_more_tiles;
  logic                w_more_grps;
  logic                w_unused_valids;

  // Unit 0 / row 0 is the reference lane for drain accounting.
  assign w_out_v         = pu_out_valids[0];
  assign w_unused_valids = ^pu_out_valids[UNIT_NUM*4-1:1];

  assign w_cfg_ok     = (cfg_width >= c_K) && (cfg_row_tiles != '0) && (cfg_ch_groups != '0);
  assign w_accept     = (r_state == S_IDLE) && start && w_cfg_ok;
  assign w_hit        = r_out_cnt >= (r_width - c_K + COL_AW'(1));
  assign w_last_col   = r_col == (r_width - COL_AW'(1));
  assign w_more_tiles = r_tile < (r_rows - TILE_W'(1));
  assign w_more_grps  = r_grp < (r_grps - GRP_W'(1));

`ifdef DWC_SCHED_WATCHDOG_EN
  logic [11:0] r_wd;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_wd <= 12'd0;
    else        r_wd <= (r_state == S_DRAIN && !w_out_v) ? r_wd + 12'd1 : 12'd0;
  end
`endif

  always_comb begin
    w_next    = r_state;
    w_rd_en   = 1'b0;
    w_load    = 1'b0;
    col_rd_en = 1'b0;
    tile_done = 1'b0;
    done      = 1'b0;
`ifdef DWC_SCHED_WATCHDOG_EN
    err_timeout = 1'b0;
`endif
    case (r_state)
      S_IDLE: if (w_accept) w_next = S_LOAD_W;
      S_LOAD_W: begin
        if (!r_lw_phase) w_rd_en = 1'b1;
        else begin
          w_load = 1'b1;
          w_next = S_STREAM;
        end
      end
      S_STREAM: begin
        if (col_rdy) begin
          col_rd_en = 1'b1;
          if (w_last_col) w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_hit) begin
          tile_done = 1'b1;
          if (w_more_tiles)     w_next = S_STREAM;
          else if (w_more_grps) w_next = S_LOAD_W;
          else                  w_next = S_DONE;
        end
`ifdef DWC_SCHED_WATCHDOG_EN
        else if (r_wd == 12'hFFF) begin
          err_timeout = 1'b1;
          w_next      = S_IDLE;
        end
`endif
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_lw_phase    <= 1'b0;
      r_width       <= '0;
      r_rows        <= '0;
      r_grps        <= '0;
      r_col         <= '0;
      r_tile        <= '0;
      r_grp         <= '0;
      r_out_cnt     <= '0;
      r_cfg_err     <= 1'b0;
      r_pu_in_valid <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_lw_phase    <= (r_state == S_LOAD_W) && !r_lw_phase;
      r_cfg_err     <= (r_state == S_IDLE) && start && !w_cfg_ok;
      r_pu_in_valid <= col_rd_en;

      if (w_accept) begin
        r_width <= cfg_width;
        r_rows  <= cfg_row_tiles;
        r_grps  <= cfg_ch_groups;
        r_col   <= '0;
        r_tile  <= '0;
        r_grp   <= '0;
      end else if (col_rd_en) begin
        r_col <= r_col + COL_AW'(1);
      end else if (tile_done) begin
        r_col <= '0;
        if (w_more_tiles) r_tile <= r_tile + TILE_W'(1);
        else if (w_more_grps) begin
          r_tile <= '0;
          r_grp  <= r_grp + GRP_W'(1);
        end
      end

      // Outputs landing during STREAM belong to the current tile too.
      if (w_next == S_STREAM && r_state != S_STREAM)
        r_out_cnt <= '0;
      else if ((r_state == S_STREAM || r_state == S_DRAIN) && w_out_v)
        r_out_cnt <= r_out_cnt + COL_AW'(1);
    end
  end

  assign busy        = r_state != S_IDLE;
  assign w_rd_grp    = r_grp;
  assign col_rd_addr = r_col;
  assign col_rd_tile = r_tile;
  assign col_rd_grp  = r_grp;
  assign pu_in_valid = r_pu_in_valid;
  assign cfg_err     = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_dwc_sched.sv
`default_nettype none
//------------------------------------------------------------------------------
// tb_dwc_sched : directed self-checking bench for dwc_sched
// Rev 1.0
//------------------------------------------------------------------------------
module tb_dwc_sched;
  localparam int UNIT_NUM = 16;
  localparam int K        = 3;
  localparam int COL_AW   = 10;
  localparam int TILE_W   = 8;
  localparam int GRP_W    = 8;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  start;
  logic [COL_AW-1:0]     cfg_width;
  logic [TILE_W-1:0]     cfg_row_tiles;
  logic [GRP_W-1:0]      cfg_ch_groups;
  logic                  w_rd_en;
  logic [GRP_W-1:0]      w_rd_grp;
  logic                  w_load;
  logic                  col_rdy;
  logic                  col_rd_en;
  logic [COL_AW-1:0]     col_rd_addr;
  logic [TILE_W-1:0]     col_rd_tile;
  logic [GRP_W-1:0]      col_rd_grp;
  logic                  pu_in_valid;
  logic [UNIT_NUM*4-1:0] pu_out_valids;
  logic                  busy;
  logic                  tile_done;
  logic                  done;
  logic                  cfg_err;
`ifdef DWC_SCHED_WATCHDOG_EN
  logic                  err_timeout;
`endif

  dwc_sched #(.UNIT_NUM(UNIT_NUM), .K(K), .COL_AW(COL_AW), .TILE_W(TILE_W), .GRP_W(GRP_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_width(cfg_width), .cfg_row_tiles(cfg_row_tiles), .cfg_ch_groups(cfg_ch_groups),
    .w_rd_en(w_rd_en), .w_rd_grp(w_rd_grp), .w_load(w_load),
    .col_rdy(col_rdy), .col_rd_en(col_rd_en), .col_rd_addr(col_rd_addr),
    .col_rd_tile(col_rd_tile), .col_rd_grp(col_rd_grp),
    .pu_in_valid(pu_in_valid), .pu_out_valids(pu_out_valids),
    .busy(busy), .tile_done(tile_done), .done(done),
`ifdef DWC_SCHED_WATCHDOG_EN
    .err_timeout(err_timeout),
`endif
    .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  // PU model: every input after the first K-1 of a tile yields one output, 3 cycles later.
  logic [2:0] pipe;
  int         in_cnt;
  logic       pu_en;
  assign pu_out_valids = {(UNIT_NUM*4){pipe[2]}};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe   <= 3'd0;
      in_cnt <= 0;
    end else begin
      pipe <= {pipe[1:0], pu_en && pu_in_valid && (in_cnt >= K-1)};
      if (tile_done || !busy) in_cnt <= 0;
      else if (pu_in_valid)   in_cnt <= in_cnt + 1;
    end
  end

  // Event logger, sampled on the falling edge.
  logic [COL_AW-1:0] addr_log [0:255];
  logic [TILE_W-1:0] tile_log [0:255];
  logic [GRP_W-1:0]  grp_log  [0:255];
  logic [GRP_W-1:0]  wgrp_log [0:15];
  int n_rd = 0, n_wrd = 0, n_wload = 0, n_tdone = 0, n_done = 0, n_cfgerr = 0, n_mirror_bad = 0;
  logic prev_en = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_en <= 1'b0;
    end else begin
      if (pu_in_valid !== prev_en) n_mirror_bad <= n_mirror_bad + 1;
      prev_en <= col_rd_en;
      if (col_rd_en && n_rd < 256) begin
        addr_log[n_rd] <= col_rd_addr;
        tile_log[n_rd] <= col_rd_tile;
        grp_log[n_rd]  <= col_rd_grp;
        n_rd <= n_rd + 1;
      end
      if (w_rd_en && n_wrd < 16) begin
        wgrp_log[n_wrd] <= w_rd_grp;
        n_wrd <= n_wrd + 1;
      end
      if (w_load)    n_wload  <= n_wload + 1;
      if (tile_done) n_tdone  <= n_tdone + 1;
      if (done)      n_done   <= n_done + 1;
      if (cfg_err)   n_cfgerr <= n_cfgerr + 1;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int w, input int t, input int g);
    cfg_width     = COL_AW'(w);
    cfg_row_tiles = TILE_W'(t);
    cfg_ch_groups = GRP_W'(g);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int bound);
    logic found = 1'b0;
    for (int i = 0; i < bound && !found; i++) begin
      if (done) found = 1'b1;
      else tick();
    end
    check(tag, 64'(found), 64'd1);
    tick();
  endtask

  task automatic wait_addr(input string tag, input int a, input int bound);
    logic found = 1'b0;
    for (int i = 0; i < bound && !found; i++) begin
      if (col_rd_en && col_rd_addr == COL_AW'(a)) found = 1'b1;
      else tick();
    end
    check(tag, 64'(found), 64'd1);
  endtask

  task automatic check_reads(input string tag, input int base, input int cnt, input int w, input int t);
    int bad = 0;
    check({tag, "_cnt"}, 64'(n_rd - base), 64'(cnt));
    for (int i = 0; i < cnt; i++) begin
      if (addr_log[base+i] !== COL_AW'(i % w))       bad++;
      if (tile_log[base+i] !== TILE_W'((i / w) % t)) bad++;
      if (grp_log[base+i]  !== GRP_W'(i / (w * t)))  bad++;
    end
    check({tag, "_seq"}, 64'(bad), 64'd0);
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({w_rd_en, w_rd_grp, w_load, col_rd_en, col_rd_addr, col_rd_tile, col_rd_grp,
                pu_in_valid, busy, tile_done, done, cfg_err});
  endfunction

  initial begin
    int b_rd, b_wrd, b_wl, b_td, b_dn, b_ce, stall_low, bad;
    rst_n = 1'b0; start = 1'b0; cfg_width = '0; cfg_row_tiles = '0; cfg_ch_groups = '0;
    col_rdy = 1'b1; pu_en = 1'b1;
    repeat (3) tick();
    check("reset_outs", all_outs(), 64'd0);
    rst_n = 1'b1;
    tick();

    // Basic job: width 8, 2 tiles, 1 group; config changes after start must not matter.
    b_rd = n_rd; b_wl = n_wload; b_td = n_tdone; b_dn = n_done;
    start_job(8, 2, 1);
    check("t1_busy", 64'(busy), 64'd1);
    check("t1_wrd", 64'({w_rd_en, w_rd_grp}), 64'({1'b1, 8'd0}));
    cfg_width = 10'd3; cfg_row_tiles = 8'd5; cfg_ch_groups = 8'd7;
    wait_done("t1_done_seen", 300);
    check("t1_busy_after", 64'(busy), 64'd0);
    check("t1_wload", 64'(n_wload - b_wl), 64'd1);
    check_reads("t1_reads", b_rd, 16, 8, 2);
    check("t1_tdone", 64'(n_tdone - b_td), 64'd2);
    check("t1_done", 64'(n_done - b_dn), 64'd1);

    // Multi-group: width 4, 1 tile, 3 groups.
    b_rd = n_rd; b_wrd = n_wrd; b_wl = n_wload; b_td = n_tdone; b_dn = n_done;
    start_job(4, 1, 3);
    wait_done("t2_done_seen", 300);
    check("t2_wrd_cnt", 64'(n_wrd - b_wrd), 64'd3);
    bad = 0;
    for (int i = 0; i < 3; i++) if (wgrp_log[b_wrd+i] !== GRP_W'(i)) bad++;
    check("t2_wrd_grp", 64'(bad), 64'd0);
    check("t2_wload", 64'(n_wload - b_wl), 64'd3);
    check_reads("t2_reads", b_rd, 12, 4, 1);
    check("t2_tdone", 64'(n_tdone - b_td), 64'd3);
    check("t2_done", 64'(n_done - b_dn), 64'd1);

    // Stall: col_rdy low for 5 cycles right after column 3.
    b_rd = n_rd;
    start_job(8, 1, 1);
    wait_addr("t3_reach3", 3, 50);
    tick();
    col_rdy = 1'b0;
    stall_low = 0;
    repeat (5) begin
      #1;
      if (!col_rd_en && col_rd_addr == 10'd4) stall_low++;
      tick();
    end
    check("t3_stall_low", 64'(stall_low), 64'd5);
    col_rdy = 1'b1;
    #1;
    check("t3_resume", 64'({col_rd_en, col_rd_addr}), 64'({1'b1, 10'd4}));
    wait_done("t3_done_seen", 300);
    check_reads("t3_reads", b_rd, 8, 8, 1);
    check("t3_mirror", 64'(n_mirror_bad), 64'd0);

    // Bad config, then a start while busy.
    b_ce = n_cfgerr;
    start_job(2, 1, 1);
    check("t4_cfg_err", 64'({cfg_err, busy}), 64'({1'b1, 1'b0}));
    tick();
    check("t4_cfg_err_end", 64'({cfg_err, busy}), 64'd0);
    b_rd = n_rd; b_td = n_tdone;
    start_job(4, 1, 1);
    check("t4_busy", 64'(busy), 64'd1);
    cfg_width = 10'd8; cfg_row_tiles = 8'd2; cfg_ch_groups = 8'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("t4_done_seen", 300);
    check_reads("t4_reads", b_rd, 4, 4, 1);
    check("t4_tdone", 64'(n_tdone - b_td), 64'd1);
    check("t4_cfg_err_cnt", 64'(n_cfgerr - b_ce), 64'd1);

    // Reset in the middle of STREAM at column 5.
    start_job(8, 1, 1);
    wait_addr("t5_reach5", 5, 50);
    b_td = n_tdone; b_dn = n_done;
    rst_n = 1'b0;
    #1;
    check("t5_rst_outs", all_outs(), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("t5_no_pulses", 64'((n_tdone - b_td) + (n_done - b_dn)), 64'd0);
    b_rd = n_rd;
    start_job(4, 1, 1);
    check("t5_restart_wrd", 64'({w_rd_en, w_rd_grp}), 64'({1'b1, 8'd0}));
    wait_done("t5_done_seen", 300);
    check_reads("t5_reads", b_rd, 4, 4, 1);

`ifdef DWC_SCHED_WATCHDOG_EN
    // Watchdog: no outputs ever come back during DRAIN.
    begin
      logic found = 1'b0;
      int   el = 0;
      pu_en = 1'b0;
      b_dn = n_done;
      start_job(4, 1, 1);
      for (int i = 0; i < 6000 && !found; i++) begin
        if (err_timeout) begin
          found = 1'b1;
          el = i;
        end else tick();
      end
      check("t6_timeout_seen", 64'(found), 64'd1);
      check("t6_latency", 64'(el >= 4095 && el <= 4110), 64'd1);
      tick();
      check("t6_idle", 64'({busy, err_timeout}), 64'd0);
      check("t6_no_done", 64'(n_done - b_dn), 64'd0);
      pu_en = 1'b1;
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dwc_sched.md
Name: dwc_sched

Overview:
- Sequencer for the depthwise-conv processing-unit array.
- For each channel group, it loads that group's 3xK weights. It then walks every row tile of the feature map, streams columns from the column buffer into the PU array and drains the PU pipeline before moving on.
- Sits between the layer controller (start/config/done) and the column buffer, weight buffer and PU array.

Parameters:
- UNIT_NUM, 16: PU units per array; width of the out_valid vector is UNIT_NUM*4.
- K, 3: kernel width; a tile of W columns yields W-K+1 outputs per output row.
- COL_AW, 10: column address width; max image width 2^COL_AW-1.
- TILE_W, 8: row-tile counter width.
- GRP_W, 8: channel-group counter width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle job start
- cfg_width  in  COL_AW  image width in columns
- cfg_row_tiles  in  TILE_W  number of row tiles
- cfg_ch_groups  in  GRP_W  number of channel groups, UNIT_NUM channels each
- w_rd_en  out  1  weight buffer read strobe
- w_rd_grp  out  GRP_W  weight group index
- w_load  out  1  PU weight register load; data valid this cycle
- col_rdy  in  1  column buffer has data for the current address
- col_rd_en  out  1  column buffer read strobe
- col_rd_addr  out  COL_AW  column index
- col_rd_tile  out  TILE_W  row-tile index
- col_rd_grp  out  GRP_W  group index
- pu_in_valid  out  1  drives PU in_valid
- pu_out_valids  in  UNIT_NUM*4  PU output valids
- busy  out  1  job in progress
- tile_done  out  1  one-cycle pulse per completed tile
- done  out  1  one-cycle pulse at job end
- cfg_err  out  1  one-cycle pulse on rejected start

Behaviour:
- Reset: every output is 0; FSM is IDLE; all counters are 0.
- Config latch: cfg_* are registered on an accepted start; later changes have no effect until the next start.
- Start rejection: start while busy is ignored. Start with cfg_width<K, cfg_row_tiles==0 or cfg_ch_groups==0 pulses cfg_err the next cycle and the FSM stays IDLE.
- FSM state IDLE:
  - on an accepted start go to LOAD_W with grp=0, tile=0, col=0; busy=1 from the next cycle.
- FSM state LOAD_W:
  - cycle 1: w_rd_en=1, w_rd_grp=grp.
  - cycle 2: w_load=1.
  - then go to STREAM.
- FSM state STREAM:
  - each cycle col_rdy=1: col_rd_en=1 with addr=col, tile, grp; col increments.
  - col_rdy=0: col_rd_en=0 and col holds (stall, any length).
  - after reading col=cfg_width-1, go to DRAIN.
- pu_in_valid: equals col_rd_en delayed 1 cycle (buffer read latency 1). No PU input is issued outside STREAM.
- FSM state DRAIN:
  - out_cnt counts cycles where pu_out_valids[0] is 1 (unit 0, row 0 is the reference lane).
  - the counter is cleared on entering STREAM.
  - when out_cnt reaches cfg_width-K+1: pulse tile_done, clear col.
  - if tile<cfg_row_tiles-1: tile++ and go to STREAM.
  - else if grp<cfg_ch_groups-1: grp++, tile=0 and go to LOAD_W.
  - else go to DONE.
- FSM state DONE:
  - done=1 for one cycle, busy=0 from the next cycle, go to IDLE.
- Simultaneous events: an out_valid pulse on the same cycle DRAIN is entered is counted. Output valids arriving while in STREAM are also counted into out_cnt.
- Reset mid-job: asynchronous return to IDLE, outputs 0; no done or tile_done pulse is produced.
- Counters: counters are full-width, so no wrap inside a job. The column counter only compares against the latched width.

Optional Feature:
- Macro DWC_SCHED_WATCHDOG_EN.
- With the macro: DRAIN has a 12-bit idle counter, reset on any pu_out_valids[0] pulse. When it reaches 4095 cycles: one-cycle err_timeout pulse (extra output port), busy drops, FSM goes to IDLE, done is not pulsed.
- Without the macro: no port and no counter; DRAIN waits indefinitely.

Test Plan:
- Basic job, width=8, tiles=2, groups=1, col_rdy=1, model returns 6 out_valids per tile. Required:
  - one w_load;
  - 16 col_rd_en cycles, addr 0..7 twice;
  - tile_done x2;
  - done at end;
  - busy low after done.
- Multi-group, groups=3, tiles=1, width=4. Required:
  - three LOAD_W phases, w_rd_grp=0,1,2;
  - each followed by 4 reads;
  - 3 tile_done, then done.
- Stall, width=8, col_rdy low for 5 cycles after col 3. Required:
  - col_rd_en low for 5 cycles;
  - addr resumes at 4, no skip or repeat;
  - pu_in_valid mirrors col_rd_en one cycle late.
- Bad config, width=2 (K=3), plus a start while busy. Required:
  - cfg_err pulse and busy stays 0;
  - the start while busy is ignored, with no config change.
- Reset mid-STREAM at col=5. Required:
  - all outputs 0 immediately;
  - a new start runs cleanly from col 0, grp 0.
- With DWC_SCHED_WATCHDOG_EN, model withholds out_valids in DRAIN. Required:
  - err_timeout after 4095 cycles;
  - FSM returns to IDLE;
  - no done pulse.
